// File: rtl/uart_rx_param_if.sv
// Receive-FIFO side of uart_rx_param: head entry, occupancy and pop strobe.
// With UART_RX_PARITY_EN defined the head entry also carries its parity-error tag.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frm_err;
    logic                 rx_data_rdy;
    logic [FIFO_AW:0]     fifo_count;
    logic                 read_en;
`ifdef UART_RX_PARITY_EN
    logic                 rx_par_err;
`endif

    modport master (
        output rx_data, rx_frm_err, rx_data_rdy, fifo_count,
`ifdef UART_RX_PARITY_EN
        output rx_par_err,
`endif
        input  read_en
    );

    modport slave (
        input  rx_data, rx_frm_err, rx_data_rdy, fifo_count,
`ifdef UART_RX_PARITY_EN
        input  rx_par_err,
`endif
        output read_en
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: RXD synchroniser, x16 tick generator, frame FSM and FWFT FIFO.
// Optional parity checking is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_AW     = 4,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_rx,
    input  logic        rst_clk_rx,
    input  logic        rxd_i,
    input  logic [15:0] baud_div,
    input  logic        clr_err,
    uart_rx_param_if.master rx_if,
    output logic        rxd_clk_rx,
    output logic        lost_data,
    output logic        break_det,
    output logic        rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic        par_err_sticky
`endif
);

`ifdef UART_RX_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int               ENT_W   = DATA_BITS + 1 + PAR_W;
    localparam int               DEPTH_I = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW+1)'(DEPTH_I);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxd_prev_q, rxd_prev_d;
    logic [15:0]            div_q, div_d;
    logic [15:0]            tick_cnt_q, tick_cnt_d;
    state_t                 state_q, state_d;
    logic [3:0]             smp_cnt_q, smp_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   frm_err_q, frm_err_d;
    logic                   wr_q, wr_d;
    logic [ENT_W-1:0]       wr_ent_q, wr_ent_d;
    logic                   break_q, break_d;
    logic [FIFO_AW-1:0]     wptr_q, wptr_d;
    logic [FIFO_AW-1:0]     rptr_q, rptr_d;
    logic [FIFO_AW:0]       count_q, count_d;
    logic                   rdy_q, rdy_d;
    logic                   lost_q, lost_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
    logic                   par_sticky_q, par_sticky_d;
`endif

    logic                   rxd_s, tick, mid, ferr;
    logic                   pop, accept, overrun;
    logic [ENT_W-1:0]       mem_q [DEPTH_I];
    logic [ENT_W-1:0]       head;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rxd_i};
        rxd_prev_d = rxd_s;

        // Wrap on >= as well so a smaller divisor latched mid-count cannot run away.
        tick       = (tick_cnt_q == div_q);
        tick_cnt_d = (tick_cnt_q >= div_q) ? 16'd0 : tick_cnt_q + 16'd1;
        mid        = tick && (smp_cnt_q == 4'd7);

        div_d     = div_q;
        state_d   = state_q;
        smp_cnt_d = tick ? smp_cnt_q + 4'd1 : smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        frm_err_d = frm_err_q;
        ferr      = frm_err_q | ~rxd_s;
        wr_d      = 1'b0;
        wr_ent_d  = wr_ent_q;
        break_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                div_d = baud_div;
                if (rxd_prev_q && !rxd_s) begin
                    state_d   = S_START;
                    smp_cnt_d = 4'd0;
                end
            end
            S_START: begin
                if (mid) begin
                    if (rxd_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = 4'd0;
                        frm_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == 4'(DATA_BITS-1)) begin
                        bit_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid) begin
                    par_err_d = ((^shift_q) ^ rxd_s) != (PARITY_ODD != 0);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid) begin
                    if (bit_cnt_q != 4'(STOP_BITS-1)) begin
                        frm_err_d = ferr;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (shift_q == '0 && !rxd_s) begin
                        break_d = 1'b1;
                        state_d = S_BREAK_WAIT;
                    end else begin
                        // Back to IDLE at mid-stop so an immediately following start bit is seen.
                        wr_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
                        wr_ent_d = {par_err_q, ferr, shift_q};
`else
                        wr_ent_d = {ferr, shift_q};
`endif
                        state_d = S_IDLE;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pop     = rx_if.read_en && (count_q != '0);
        accept  = wr_q && ((count_q != DEPTH) || pop);
        overrun = wr_q && (count_q == DEPTH) && !pop;
        wptr_d  = wptr_q + FIFO_AW'(accept);
        rptr_d  = rptr_q + FIFO_AW'(pop);
        count_d = count_q + (FIFO_AW+1)'(accept) - (FIFO_AW+1)'(pop);
        rdy_d   = (count_d != '0);
        lost_d  = overrun | (lost_q & ~clr_err);
`ifdef UART_RX_PARITY_EN
        par_sticky_d = (wr_q & wr_ent_q[ENT_W-1]) | (par_sticky_q & ~clr_err);
`endif
    end

    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            sync_q     <= '1;
            rxd_prev_q <= 1'b1;
            div_q      <= 16'd0;
            tick_cnt_q <= 16'd0;
            state_q    <= S_IDLE;
            smp_cnt_q  <= 4'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            frm_err_q  <= 1'b0;
            wr_q       <= 1'b0;
            wr_ent_q   <= '0;
            break_q    <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rdy_q      <= 1'b0;
            lost_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
            par_sticky_q <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            rxd_prev_q <= rxd_prev_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            frm_err_q  <= frm_err_d;
            wr_q       <= wr_d;
            wr_ent_q   <= wr_ent_d;
            break_q    <= break_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rdy_q      <= rdy_d;
            lost_q     <= lost_d;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= par_err_d;
            par_sticky_q <= par_sticky_d;
`endif
        end
    end

    // Storage is not reset; the head is masked by rdy_q so stale words never show.
    always_ff @(posedge clk_rx) begin
        if (accept) mem_q[wptr_q] <= wr_ent_q;
    end

    assign head              = mem_q[rptr_q];
    assign rx_if.rx_data     = rdy_q ? head[DATA_BITS-1:0] : '0;
    assign rx_if.rx_frm_err  = rdy_q & head[DATA_BITS];
    assign rx_if.rx_data_rdy = rdy_q;
    assign rx_if.fifo_count  = count_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.rx_par_err  = rdy_q & head[DATA_BITS+1];
    assign par_err_sticky    = par_sticky_q;
`endif

    assign rxd_clk_rx = rxd_s;
    assign lost_data  = lost_q;
    assign break_det  = break_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule
